out_port_receiver: RTL and testbench
====================================

# out_port_receiver

Receives words from the processor's output port (outPortData qualified by the one-cycle strobe outSignalEn) and buffers them in a small FIFO. An external consumer drains the FIFO through a valid/ready handshake. The block sits outside the Controller, on the far end of its OUT-instruction path, and reports occupancy, an almost-full warning and sticky overflow status with a saturating drop counter.

## Interface
- DATA_WIDTH, 16, width of one port word
- DEPTH, 8, FIFO entries; must be a power of two, at least 2
- ALMOST_FULL, 6, occupancy at or above which almostFull asserts; must satisfy 1 ≤ ALMOST_FULL ≤ DEPTH

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- outPortData  in  DATA_WIDTH  word driven by the processor's OUT instruction
- outSignalEn  in  1  write strobe; each high cycle is one word
- rxData  out  DATA_WIDTH  FIFO head word; 0 whenever rxValid=0
- rxValid  out  1  FIFO non-empty
- rxReady  in  1  consumer accepts the head word this cycle
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almostFull  out  1  count ≥ ALMOST_FULL
- overflow  out  1  sticky; set when a word is dropped
- dropCount  out  8  number of dropped words, saturating at 255
- clearOverflow  in  1  clears overflow and dropCount

## Operation
- Storage is a DEPTH-entry array, with rdPtr and wrPtr each $clog2(DEPTH) bits wide.
  - Pointers wrap modulo DEPTH.
  - Full and empty are determined from count, not from pointer equality.
- Push happens when outSignalEn=1 and the write is accepted.
- Pop happens when rxValid=1 and rxReady=1.
- Write acceptance:
  - count < DEPTH: the word is accepted.
  - count = DEPTH and a pop occurs the same cycle: the word is accepted and count stays at DEPTH.
  - count = DEPTH and no pop: the word is dropped. overflow is set to 1 and dropCount increments, saturating at 255.
- Push and pop in the same cycle, not full: both happen and count is unchanged.
- Push while empty: there is no bypass. The word appears on rxData with rxValid=1 on the next cycle.
- rxReady while rxValid=0 has no effect.
- clearOverflow=1 sets overflow=0 and dropCount=0.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and dropCount=1.
- outPortData is ignored whenever outSignalEn=0.
- Status outputs are all registered or derived from registered count:
  - rxValid = (count≠0)
  - almostFull = (count≥ALMOST_FULL)

## Timing
- Reset (reset=1 at a clock edge):
  - count, rdPtr, wrPtr, overflow and dropCount all become 0.
  - Outputs: rxValid=0, rxData=0, almostFull=0.
  - FIFO array contents are don't-care.
  - Reset mid-operation discards all buffered words, including a push or pop presented in the reset cycle.
- Write latency: a strobe at edge N gives rxValid=1 and the word on rxData after edge N, i.e. visible in cycle N+1.
- Handshake:
  - While rxValid=1 and rxReady=0, rxData and rxValid hold stable.
  - After a pop at edge N, rxData shows the next entry (or 0 with rxValid=0 if the FIFO empties) in cycle N+1.
- Throughput: one push and one pop per cycle, sustained indefinitely when the consumer holds rxReady=1.
- count, almostFull, overflow and dropCount all reflect the effects of edge N during cycle N+1.
- No combinational path from outSignalEn or outPortData to any output. rxReady affects outputs only after the clock edge.

## Test plan
- Reset, then three strobes with 0x0026, 0x0001, 0x000B, rxReady=0:
  - one cycle after the first strobe, rxValid=1 and rxData=0x0026;
  - after the third strobe, count=3 and almostFull=0;
  - then rxReady=1 for 3 cycles yields 0x0026, 0x0001, 0x000B in order, ending with rxValid=0, rxData=0 and count=0.
- Fill with 8 words 0x1000..0x1007, rxReady=0:
  - almostFull rises the cycle after the 6th write;
  - count=8;
  - a 9th strobe 0xDEAD is dropped: overflow=1, dropCount=1;
  - draining returns 0x1000..0x1007 only.
- Full FIFO, strobe 0x2222 with rxReady=1 in the same cycle:
  - 0x1000 is popped, 0x2222 is accepted, count stays 8, overflow stays 0;
  - 0x2222 drains last.
- Full FIFO with rxReady=0, 300 strobes:
  - dropCount saturates at 255;
  - clearOverflow=1 together with one more drop gives overflow=1, dropCount=1;
  - a further clearOverflow with no strobe gives overflow=0, dropCount=0.
- Pointer wrap: continuous strobes 0x0000..0x0013 (20 words) with rxReady=1 throughout:
  - count never exceeds 1;
  - the output sequence equals the input sequence, each delayed one cycle;
  - the pointers wrap twice.
- Reset asserted with count=5 and a simultaneous strobe 0x7777:
  - next cycle count=0, rxValid=0, rxData=0, overflow=0;
  - 0x7777 never appears at the output.

Source files
------------

// File: rtl/out_port_receiver_if.sv
// Bus between the processor's OUT port, the receive FIFO and its downstream consumer.
// The slave modport is the receiver; the master modport is the producer/consumer side.
interface out_port_receiver_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] outPortData;
    logic                  outSignalEn;
    logic [DATA_WIDTH-1:0] rxData;
    logic                  rxValid;
    logic                  rxReady;
    logic [CW-1:0]         count;
    logic                  almostFull;
    logic                  overflow;
    logic [7:0]            dropCount;
    logic                  clearOverflow;

    modport slave (
        input  outPortData, outSignalEn, rxReady, clearOverflow,
        output rxData, rxValid, count, almostFull, overflow, dropCount
    );

    modport master (
        output outPortData, outSignalEn, rxReady, clearOverflow,
        input  rxData, rxValid, count, almostFull, overflow, dropCount
    );
endinterface

// File: rtl/out_port_receiver.sv
// Receive FIFO for the processor's OUT port: strobed writes in, valid/ready reads out,
// with occupancy, almost-full and sticky overflow / saturating drop-count status.
module out_port_receiver #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int ALMOST_FULL = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    out_port_receiver_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rdPtr;
    logic [PW-1:0]         wrPtr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [7:0]            dropCount;

    logic full;
    logic nonEmpty;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    always_comb begin
        full     = (count == DEPTH_C);
        nonEmpty = (count != '0);
        pop      = nonEmpty && bus.rxReady;
        push     = bus.outSignalEn && (!full || pop);
        drop     = bus.outSignalEn && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wrPtr] <= bus.outPortData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            dropCount <= 8'd0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves a fresh count of one.
            if (drop) begin
                overflow  <= 1'b1;
                dropCount <= bus.clearOverflow ? 8'd1 : sat_inc(dropCount);
            end else if (bus.clearOverflow) begin
                overflow  <= 1'b0;
                dropCount <= 8'd0;
            end
        end
    end

    always_comb begin
        bus.rxValid    = nonEmpty;
        bus.rxData     = nonEmpty ? mem[rdPtr] : '0;
        bus.count      = count;
        bus.almostFull = (count >= AF_C);
        bus.overflow   = overflow;
        bus.dropCount  = dropCount;
    end
endmodule

// File: tb/tb_out_port_receiver.sv
// Directed and randomized bench for out_port_receiver, checked against a queue-based model.
module tb_out_port_receiver;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    out_port_receiver_if #(.DATA_WIDTH(16), .DEPTH(8)) bus ();

    out_port_receiver #(.DATA_WIDTH(16), .DEPTH(8), .ALMOST_FULL(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO contents as a plain queue of words.
    logic [15:0] q[$];
    bit          m_ovf;
    int          m_drops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit en, input logic [15:0] d, input bit rdy,
                              input bit clr, input bit rst_i);
        bit popped;
        bit full_now;
        if (rst_i) begin
            q.delete();
            m_ovf   = 0;
            m_drops = 0;
            return;
        end
        popped   = (q.size() > 0) && rdy;
        full_now = (q.size() == 8);
        if (popped) void'(q.pop_front());
        if (en && (!full_now || popped)) begin
            q.push_back(d);
            if (clr) begin m_ovf = 0; m_drops = 0; end
        end else if (en) begin
            m_ovf   = 1;
            m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (clr) begin
            m_ovf   = 0;
            m_drops = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".valid"}, 32'(bus.rxValid), 32'(n != 0));
        chk({tag, ".data"}, 32'(bus.rxData), (n != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".count"}, 32'(bus.count), 32'(n));
        chk({tag, ".af"}, 32'(bus.almostFull), 32'(n >= 6));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".drops"}, 32'(bus.dropCount), 32'(m_drops));
    endtask

    task automatic cyc(input string tag, input bit en, input logic [15:0] d, input bit rdy,
                       input bit clr = 0, input bit rst_i = 0);
        bus.outSignalEn   = en;
        bus.outPortData   = d;
        bus.rxReady       = rdy;
        bus.clearOverflow = clr;
        reset             = rst_i;
        @(posedge clk);
        model_edge(en, d, rdy, clr, rst_i);
        #1;
        check_all(tag);
    endtask

    task automatic drain_expect(input string tag, input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".head"}, 32'(bus.rxData), 32'(first + 16'(i)));
            cyc(tag, 0, 16'h0, 1);
        end
    endtask

    initial begin
        bus.outSignalEn = 0; bus.outPortData = 0; bus.rxReady = 0; bus.clearOverflow = 0;
        reset = 1;
        m_ovf = 0; m_drops = 0;

        cyc("rst", 0, 16'h0, 0, 0, 1);
        chk("rst.count", 32'(bus.count), 32'd0);
        chk("rst.data", 32'(bus.rxData), 32'd0);

        // Three words, then read them back.
        cyc("s3a", 1, 16'h0026, 0);
        chk("s3.first_valid", 32'(bus.rxValid), 32'd1);
        chk("s3.first_data", 32'(bus.rxData), 32'h0026);
        cyc("s3b", 1, 16'h0001, 0);
        cyc("s3c", 1, 16'h000B, 0);
        chk("s3.count", 32'(bus.count), 32'd3);
        chk("s3.af", 32'(bus.almostFull), 32'd0);
        cyc("s3d", 0, 16'h0, 1);
        chk("s3.second", 32'(bus.rxData), 32'h0001);
        cyc("s3e", 0, 16'h0, 1);
        chk("s3.third", 32'(bus.rxData), 32'h000B);
        cyc("s3f", 0, 16'h0, 1);
        chk("s3.empty_valid", 32'(bus.rxValid), 32'd0);
        chk("s3.empty_data", 32'(bus.rxData), 32'd0);
        chk("s3.empty_count", 32'(bus.count), 32'd0);

        // Fill to DEPTH, then one dropped word.
        for (int i = 0; i < 8; i++) begin
            cyc("fill", 1, 16'h1000 + 16'(i), 0);
            if (i == 4) chk("fill.af_before", 32'(bus.almostFull), 32'd0);
            if (i == 5) chk("fill.af_rise", 32'(bus.almostFull), 32'd1);
        end
        chk("fill.count", 32'(bus.count), 32'd8);
        cyc("drop1", 1, 16'hDEAD, 0);
        chk("drop1.ovf", 32'(bus.overflow), 32'd1);
        chk("drop1.drops", 32'(bus.dropCount), 32'd1);
        drain_expect("drain1", 16'h1000, 8);
        chk("drain1.empty", 32'(bus.rxValid), 32'd0);

        // Full FIFO: push with a simultaneous pop is accepted.
        cyc("clr1", 0, 16'h0, 0, 1);
        for (int i = 0; i < 8; i++) cyc("fill2", 1, 16'h1000 + 16'(i), 0);
        cyc("pushpop", 1, 16'h2222, 1);
        chk("pushpop.count", 32'(bus.count), 32'd8);
        chk("pushpop.ovf", 32'(bus.overflow), 32'd0);
        chk("pushpop.head", 32'(bus.rxData), 32'h1001);
        drain_expect("drain2", 16'h1001, 7);
        chk("drain2.last", 32'(bus.rxData), 32'h2222);
        cyc("drain2x", 0, 16'h0, 1);

        // Saturating drop counter and clear/drop priority.
        for (int i = 0; i < 8; i++) cyc("fill3", 1, 16'h3000 + 16'(i), 0);
        for (int i = 0; i < 300; i++) cyc("sat", 1, 16'(i), 0);
        chk("sat.drops", 32'(bus.dropCount), 32'd255);
        cyc("clrdrop", 1, 16'hBEEF, 0, 1);
        chk("clrdrop.ovf", 32'(bus.overflow), 32'd1);
        chk("clrdrop.drops", 32'(bus.dropCount), 32'd1);
        cyc("clr2", 0, 16'h0, 0, 1);
        chk("clr2.ovf", 32'(bus.overflow), 32'd0);
        chk("clr2.drops", 32'(bus.dropCount), 32'd0);
        drain_expect("drain3", 16'h3000, 8);

        // Streaming through with the consumer always ready: pointers wrap twice.
        for (int i = 0; i < 20; i++) begin
            cyc("wrap", 1, 16'(i), 1);
            chk("wrap.count_le1", 32'(bus.count <= 1), 32'd1);
            chk("wrap.data", 32'(bus.rxData), 32'(i));
        end
        cyc("wrap_end", 0, 16'h0, 1);
        chk("wrap_end.valid", 32'(bus.rxValid), 32'd0);

        // Reset with buffered words and a strobe in the reset cycle.
        for (int i = 0; i < 5; i++) cyc("pre_rst", 1, 16'h5000 + 16'(i), 0);
        cyc("mid_rst", 1, 16'h7777, 0, 0, 1);
        chk("mid_rst.count", 32'(bus.count), 32'd0);
        chk("mid_rst.valid", 32'(bus.rxValid), 32'd0);
        chk("mid_rst.data", 32'(bus.rxData), 32'd0);
        chk("mid_rst.ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc("post_rst", 0, 16'h0, 1);
            chk("post_rst.no7777", 32'(bus.rxData != 16'h7777), 32'd1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cyc("rand", ($urandom_range(0, 99) < 60), 16'($urandom), ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
